// File: rtl/dmem_pkg.sv
// Shared constants, port-index type and saturating increment for the dual-port data-memory responder.
package dmem_pkg;

    localparam int DMEM_DEPTH = 32;
    localparam int DMEM_AW    = 5;
    localparam int DMEM_DW    = 32;
    localparam int DMEM_CNT_W = 16;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    function automatic logic [DMEM_CNT_W-1:0] sat_inc(input logic [DMEM_CNT_W-1:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; grants are combinational and forced low during reset.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_e last_gnt_q;

    always_comb begin
        gnt_o = 2'b00;
        if (!rst_i) begin
            if (&req_i) begin
                gnt_o = (last_gnt_q == PORT1) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Pointer starts at PORT1 so port 0 wins the first conflict after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_q <= PORT1;
        end else if (gnt_o[0]) begin
            last_gnt_q <= PORT0;
        end else if (gnt_o[1]) begin
            last_gnt_q <= PORT1;
        end
    end

endmodule

// File: rtl/dmem_dual_responder.sv
// Single-ported word array shared by two CPU memory-stage buses, one access per cycle, 1-cycle read latency.
// Optional per-port access and conflict counters when DMEM_ACCESS_COUNT_EN is defined.
module dmem_dual_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = DMEM_AW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req0_i,
    input  logic               we0_i,
    input  logic [DMEM_DW-1:0] addr0_i,
    input  logic [DMEM_DW-1:0] wdata0_i,
    output logic               gnt0_o,
    output logic               rvalid0_o,
    output logic [DMEM_DW-1:0] rdata0_o,
    input  logic               req1_i,
    input  logic               we1_i,
    input  logic [DMEM_DW-1:0] addr1_i,
    input  logic [DMEM_DW-1:0] wdata1_i,
    output logic               gnt1_o,
    output logic               rvalid1_o,
    output logic [DMEM_DW-1:0] rdata1_o
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [DMEM_CNT_W-1:0] acc0_o,
    output logic [DMEM_CNT_W-1:0] acc1_o,
    output logic [DMEM_CNT_W-1:0] conf_o
`endif
);

    logic [1:0]         req;
    logic [1:0]         gnt;
    logic [AW-1:0]      idx0;
    logic [AW-1:0]      idx1;
    logic               wr_en;
    logic [AW-1:0]      wr_idx;
    logic [DMEM_DW-1:0] wr_data;
    logic [1:0]         rvalid_d;
    logic [1:0]         rvalid_q;
    logic [DMEM_DW-1:0] rdata0_q;
    logic [DMEM_DW-1:0] rdata1_q;
    logic [DMEM_DW-1:0] mem_q [DEPTH];
    logic               unused_addr;

    assign req = {req1_i, req0_i};

    rr_arbiter2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign gnt0_o = gnt[0];
    assign gnt1_o = gnt[1];

    // Byte offset and bits above the array wrap are don't-care.
    assign idx0 = addr0_i[AW+1:2];
    assign idx1 = addr1_i[AW+1:2];
    assign unused_addr = ^{addr0_i[DMEM_DW-1:AW+2], addr0_i[1:0],
                           addr1_i[DMEM_DW-1:AW+2], addr1_i[1:0]};

    always_comb begin
        wr_en    = (gnt[0] & we0_i) | (gnt[1] & we1_i);
        wr_idx   = gnt[1] ? idx1 : idx0;
        wr_data  = gnt[1] ? wdata1_i : wdata0_i;
        rvalid_d = {gnt[1] & ~we1_i, gnt[0] & ~we0_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            if (rvalid_d[0]) rdata0_q <= mem_q[idx0];
            if (rvalid_d[1]) rdata1_q <= mem_q[idx1];
            if (wr_en)       mem_q[wr_idx] <= wr_data;
        end
    end

    // A read granted just before reset must not surface its pulse in the reset cycle.
    assign rvalid0_o = rvalid_q[0] & ~rst_i;
    assign rvalid1_o = rvalid_q[1] & ~rst_i;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [DMEM_CNT_W-1:0] acc0_q;
    logic [DMEM_CNT_W-1:0] acc1_q;
    logic [DMEM_CNT_W-1:0] conf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc0_q <= '0;
            acc1_q <= '0;
            conf_q <= '0;
        end else begin
            if (gnt[0]) acc0_q <= sat_inc(acc0_q);
            if (gnt[1]) acc1_q <= sat_inc(acc1_q);
            if (&req)   conf_q <= sat_inc(conf_q);
        end
    end

    assign acc0_o = acc0_q;
    assign acc1_o = acc1_q;
    assign conf_o = conf_q;
`endif

endmodule
